// File: rtl/mem_access_unit_pkg.sv
// rtl/mem_access_unit_pkg.sv - shared types, IO window default and misalign helper for the MEM stage
package mem_access_unit_pkg;

    typedef enum logic [2:0] {
        MEM_BYTE  = 3'd0,
        MEM_HALF  = 3'd1,
        MEM_WORD  = 3'd2,
        MEM_UBYTE = 3'd3,
        MEM_UHALF = 3'd4
    } mem_mask_t;

    typedef enum logic [1:0] {
        BUS_IDLE = 2'd0,
        BUS_REQ  = 2'd1,
        BUS_DONE = 2'd2
    } bus_state_t;

    localparam logic [19:0] IO_BASE_DEFAULT = 20'h40000;

    // Halfwords need an even address, words a 4-byte aligned one; bytes never fault.
    function automatic logic is_misaligned(input mem_mask_t mem_type, input logic [1:0] offset);
        case (mem_type)
            MEM_HALF, MEM_UHALF: return offset[0];
            MEM_WORD:            return offset != 2'b00;
            default:             return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_bank.sv
// rtl/mem_access_unit_bank.sv - one byte-lane data RAM bank with registered read port
module mem_access_unit_bank #(
    parameter int DEPTH     = 16384,
    parameter     INIT_FILE = ""
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [7:0]               wdata,
    output logic [7:0]               rdata
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // The read register is the WB-stage copy, so it clears with the rest of MEM/WB.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= 8'h00;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage data access: byte-lane RAM, IO bus FSM with timeout, WB align/extend
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int          DEPTH     = 16384,
    parameter logic [19:0] IO_BASE   = IO_BASE_DEFAULT,
    parameter int          TIMEOUT   = 255,
    parameter              INIT_FILE = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        m_MemRead,
    input  logic        m_MemWrite,
    input  mem_mask_t   m_mem_type,
    input  logic [31:0] m_alu_out,
    input  logic [31:0] m_mem_data,
    input  logic [31:0] wb_data,
    input  logic        wb_forward,
    output logic [31:0] b_addr_o,
    output logic [31:0] b_data_o,
    output logic        b_read_o,
    output logic        b_write_o,
    input  logic [31:0] b_data_i,
    input  logic        b_ack_i,
    output logic        stall_mem,
    output logic [31:0] read_data_MEMWB,
    output logic        misalign_o,
    output logic        bus_err_o
);

    localparam int          AW         = $clog2(DEPTH);
    localparam logic [15:0] TIMEOUT_M1 = 16'(TIMEOUT - 1);

    logic [1:0]    offset;
    logic          access;
    logic          is_io;
    logic          misaligned;
    logic          local_ok;
    logic          io_req;
    logic          advance;
    logic [31:0]   store_src;
    logic [31:0]   store_rep;
    logic [3:0]    lanes;
    logic [3:0]    bank_we;
    logic [3:0]    bank_re;
    logic [AW-1:0] bank_addr;
    logic [31:0]   bank_word;

    bus_state_t    state_q;
    bus_state_t    state_d;
    logic          launch;
    logic          finish_ack;
    logic          finish_to;
    logic [15:0]   cnt_q;
    logic [31:0]   bus_data_q;
    logic          bus_err_q;

    mem_mask_t     wb_type;
    logic [1:0]    wb_off;
    logic          wb_io;
    logic [31:0]   wb_bus_data;
    logic          wb_err;
    logic [31:0]   wb_raw;
    logic [31:0]   wb_shifted;

    assign offset     = m_alu_out[1:0];
    assign access     = m_MemRead || m_MemWrite;
    assign is_io      = (m_alu_out[31:12] == IO_BASE);
    assign misaligned = is_misaligned(m_mem_type, offset);
    assign misalign_o = access && misaligned;
    assign local_ok   = !is_io && !misaligned;
    assign io_req     = access && is_io && !misaligned;
    assign store_src  = wb_forward ? wb_data : m_mem_data;
    assign bank_addr  = m_alu_out[AW+1:2];

    // Lane decode; narrow store data is replicated so each lane sees its own byte.
    always_comb begin
        lanes     = 4'b0000;
        store_rep = store_src;
        case (m_mem_type)
            MEM_BYTE, MEM_UBYTE: begin
                lanes     = 4'b0001 << offset;
                store_rep = {4{store_src[7:0]}};
            end
            MEM_HALF, MEM_UHALF: begin
                lanes     = offset[1] ? 4'b1100 : 4'b0011;
                store_rep = {2{store_src[15:0]}};
            end
            MEM_WORD: lanes = 4'b1111;
            default:  lanes = 4'b0000;
        endcase
    end

    // A read+write pair behaves as a write, so the read enable defers to m_MemWrite.
    assign bank_we = (m_MemWrite && local_ok) ? lanes : 4'b0000;
    assign bank_re = (m_MemRead && !m_MemWrite && local_ok && advance) ? lanes : 4'b0000;

    for (genvar i = 0; i < 4; i++) begin : g_lane
        mem_access_unit_bank #(
            .DEPTH     (DEPTH),
            .INIT_FILE (INIT_FILE)
        ) u_bank (
            .clk   (clk),
            .rst   (rst),
            .we    (bank_we[i]),
            .re    (bank_re[i]),
            .addr  (bank_addr),
            .wdata (store_rep[8*i +: 8]),
            .rdata (bank_word[8*i +: 8])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BUS_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        stall_mem  = 1'b0;
        launch     = 1'b0;
        finish_ack = 1'b0;
        finish_to  = 1'b0;
        case (state_q)
            BUS_IDLE: begin
                stall_mem = io_req;
                if (io_req && !stall) begin
                    launch  = 1'b1;
                    state_d = BUS_REQ;
                end
            end
            BUS_REQ: begin
                stall_mem = 1'b1;
                if (b_ack_i) begin
                    finish_ack = 1'b1;
                    state_d    = BUS_DONE;
                end else if (cnt_q == TIMEOUT_M1) begin
                    finish_to = 1'b1;
                    state_d   = BUS_DONE;
                end
            end
            BUS_DONE: begin
                if (!stall) begin
                    state_d = BUS_IDLE;
                end
            end
            default: state_d = BUS_IDLE;
        endcase
    end

    assign advance = !stall && !stall_mem;

    // Strobes, address and data are registered so the bus sees them stable through REQ.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= 16'd0;
            b_read_o   <= 1'b0;
            b_write_o  <= 1'b0;
            b_addr_o   <= 32'd0;
            b_data_o   <= 32'd0;
            bus_data_q <= 32'd0;
            bus_err_q  <= 1'b0;
        end else if (launch) begin
            cnt_q     <= 16'd0;
            b_addr_o  <= m_alu_out;
            b_data_o  <= store_rep;
            b_write_o <= m_MemWrite;
            b_read_o  <= !m_MemWrite;
        end else if (state_q == BUS_REQ) begin
            cnt_q <= cnt_q + 16'd1;
            if (finish_ack) begin
                bus_data_q <= b_data_i;
                bus_err_q  <= 1'b0;
                b_read_o   <= 1'b0;
                b_write_o  <= 1'b0;
            end else if (finish_to) begin
                bus_data_q <= 32'd0;
                bus_err_q  <= 1'b1;
                b_read_o   <= 1'b0;
                b_write_o  <= 1'b0;
            end
        end
    end

    // MEM/WB copy; the io flag comes from DONE so a misaligned IO-tagged access reads the banks.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_type     <= MEM_BYTE;
            wb_off      <= 2'b00;
            wb_io       <= 1'b0;
            wb_bus_data <= 32'd0;
            wb_err      <= 1'b0;
        end else if (advance) begin
            wb_type     <= m_mem_type;
            wb_off      <= offset;
            wb_io       <= (state_q == BUS_DONE);
            wb_bus_data <= bus_data_q;
            wb_err      <= (state_q == BUS_DONE) && bus_err_q;
        end
    end

    assign wb_raw     = wb_io ? wb_bus_data : bank_word;
    assign wb_shifted = wb_raw >> {wb_off, 3'b000};
    assign bus_err_o  = wb_err;

    always_comb begin
        read_data_MEMWB = wb_raw;
        case (wb_type)
            MEM_BYTE:  read_data_MEMWB = {{24{wb_shifted[7]}}, wb_shifted[7:0]};
            MEM_UBYTE: read_data_MEMWB = {24'd0, wb_shifted[7:0]};
            MEM_HALF:  read_data_MEMWB = {{16{wb_shifted[15]}}, wb_shifted[15:0]};
            MEM_UHALF: read_data_MEMWB = {16'd0, wb_shifted[15:0]};
            default:   read_data_MEMWB = wb_raw;
        endcase
    end

endmodule
